pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_ctrl_if.sv | 37 +++
 rtl/refill_fsm.sv | 50 +++++
 rtl/pipe_ctrl.sv | 75 +++++++
 tb/tb_pipe_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and encodings for the pipeline hazard / cache-refill controller.
package pipe_pkg;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_DONE} refill_st_e;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] RES_LOAD = 2'b01;

  // Register x0 is never bypassed; the memory stage holds the younger value.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wm, input logic [4:0] rdm,
                                         input logic       ww, input logic [4:0] rdw);
    if (wm && rdm != 5'd0 && rdm == rs)      return FWD_MEM;
    else if (ww && rdw != 5'd0 && rdw == rs) return FWD_WB;
    else                                     return FWD_REG;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus between the datapath (master) and pipe_ctrl (slave).
// PIPE_CTRL_PERF_EN adds the performance-counter outputs.
interface pipe_ctrl_if #(parameter int REFILL_BEATS = 4);
  localparam int BW = $clog2(REFILL_BEATS);

  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]    ResultSrcE;
  logic          RegWriteM, RegWriteW, PCSrcE;
  logic          cache_miss, mem_ready;
  logic          mem_req, refill_we;
  logic [BW-1:0] refill_beat;
  logic          stall_cache, StallF, StallD, FlushD, FlushE;
  logic [1:0]    ForwardAE, ForwardBE;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]   stall_cycles, load_use_cnt, flush_cnt;
`endif

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, cache_miss, mem_ready,
    input  mem_req, refill_we, refill_beat, stall_cache,
           StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
`ifdef PIPE_CTRL_PERF_EN
           , stall_cycles, load_use_cnt, flush_cnt
`endif
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, cache_miss, mem_ready,
    output mem_req, refill_we, refill_beat, stall_cache,
           StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
`ifdef PIPE_CTRL_PERF_EN
           , stall_cycles, load_use_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/refill_fsm.sv
// Cache-line refill sequencer: request, collect REFILL_BEATS words, release.
module refill_fsm
  import pipe_pkg::*;
#(
  parameter int REFILL_BEATS = 4,
  localparam int BW = $clog2(REFILL_BEATS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cache_miss,
  input  logic          i_mem_ready,
  output logic          o_mem_req,
  output logic          o_refill_we,
  output logic [BW-1:0] o_refill_beat,
  output logic          o_busy
);
  localparam logic [BW-1:0] LAST = BW'(REFILL_BEATS - 1);

  refill_st_e    r_state, w_nxt;
  logic [BW-1:0] r_beat;
  logic          w_beat_we;

  assign w_beat_we = (r_state == S_FILL) && i_mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_beat_we) r_beat <= (r_beat == LAST) ? '0 : r_beat + 1'b1;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_cache_miss) w_nxt = S_REQ;
      S_REQ:   w_nxt = S_FILL;
      S_FILL:  if (w_beat_we && r_beat == LAST) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  assign o_mem_req     = (r_state == S_REQ);
  assign o_refill_we   = w_beat_we;
  assign o_refill_beat = r_beat;
  assign o_busy        = (r_state != S_IDLE);
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use bubbles, branch flush, cache-miss freeze.
// PIPE_CTRL_PERF_EN adds saturating stall / load-use / flush counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int REFILL_BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);
  logic w_busy, w_stall, w_lu;

  refill_fsm #(.REFILL_BEATS(REFILL_BEATS)) u_refill (
    .clk           (clk),
    .rst           (rst),
    .i_cache_miss  (bus.cache_miss),
    .i_mem_ready   (bus.mem_ready),
    .o_mem_req     (bus.mem_req),
    .o_refill_we   (bus.refill_we),
    .o_refill_beat (bus.refill_beat),
    .o_busy        (w_busy)
  );

  assign w_stall = bus.cache_miss | w_busy;
  assign w_lu    = (bus.ResultSrcE == RES_LOAD) && (bus.RdE != 5'd0) &&
                   ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

  assign bus.ForwardAE   = fwd_sel(bus.Rs1E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
  assign bus.ForwardBE   = fwd_sel(bus.Rs2E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
  assign bus.stall_cache = w_stall;

  // A branch held in E during a freeze is not flushed; it re-resolves once the stall drops.
  always_comb begin
    bus.StallF = 1'b0;
    bus.StallD = 1'b0;
    bus.FlushD = 1'b0;
    bus.FlushE = 1'b0;
    if (w_stall) begin
      bus.StallF = 1'b1;
      bus.StallD = 1'b1;
    end else if (bus.PCSrcE) begin
      bus.FlushD = 1'b1;
      bus.FlushE = 1'b1;
    end else if (w_lu) begin
      bus.StallF = 1'b1;
      bus.StallD = 1'b1;
      bus.FlushE = 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles, r_load_use_cnt, r_flush_cnt;
  logic        w_lu_issue, w_fl_issue;

  assign w_fl_issue = !w_stall && bus.PCSrcE;
  assign w_lu_issue = !w_stall && !bus.PCSrcE && w_lu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_load_use_cnt <= '0;
      r_flush_cnt    <= '0;
    end else begin
      if (w_stall    && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_lu_issue && r_load_use_cnt != '1) r_load_use_cnt <= r_load_use_cnt + 1'b1;
      if (w_fl_issue && r_flush_cnt    != '1) r_flush_cnt    <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.load_use_cnt = r_load_use_cnt;
  assign bus.flush_cnt    = r_flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: hazard vectors and refill beats via an expectation queue.
module tb_pipe_ctrl;
  localparam int RB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.REFILL_BEATS(RB)) bus ();
  pipe_ctrl #(.REFILL_BEATS(RB)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] hz_q[$];
  logic [1:0] beat_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.Rs1D = '0; bus.Rs2D = '0; bus.Rs1E = '0; bus.Rs2E = '0; bus.RdE = '0;
    bus.RdM = '0; bus.RdW = '0; bus.ResultSrcE = '0;
    bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0; bus.PCSrcE = 1'b0;
    bus.cache_miss = 1'b0; bus.mem_ready = 1'b0;
  endtask

  function automatic logic [7:0] hz_obs();
    return {bus.ForwardAE, bus.ForwardBE, bus.StallF, bus.StallD, bus.FlushD, bus.FlushE};
  endfunction

  // exp = {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE}
  task automatic hz(input string tag,
                    input logic [4:0] r1d, r2d, r1e, r2e, rde, input logic [1:0] rs,
                    input logic wm, input logic [4:0] rdm, input logic ww, input logic [4:0] rdw,
                    input logic pc, input logic [7:0] exp);
    @(negedge clk);
    drive_idle();
    bus.Rs1D = r1d; bus.Rs2D = r2d; bus.Rs1E = r1e; bus.Rs2E = r2e; bus.RdE = rde;
    bus.ResultSrcE = rs; bus.RegWriteM = wm; bus.RdM = rdm; bus.RegWriteW = ww; bus.RdW = rdw;
    bus.PCSrcE = pc;
    hz_q.push_back(exp);
    #2;
    chk(tag, 32'(hz_obs()), 32'(hz_q.pop_front()));
  endtask

  function automatic logic rdy(input int pat, input int c);
    return (pat == 0) ? 1'b1 : (c % 2 == 0);
  endfunction

  // Cycle c=0 carries the miss; mem_ready follows the pattern on every cycle.
  task automatic run_refill(input string tag, input int pat, input logic pc);
    int c, n, last, stall_n, req_n, bad;
    logic ended;
    n = 0; c = 2;
    while (n < RB) begin
      if (rdy(pat, c)) n++;
      c++;
    end
    last = c - 1;
    stall_n = 0; req_n = 0; bad = 0; ended = 1'b0;
    for (int b = 0; b < RB; b++) beat_q.push_back(2'(b));
    for (int k = 0; k < 60 && !ended; k++) begin
      @(negedge clk);
      drive_idle();
      bus.cache_miss = (k == 0);
      bus.mem_ready  = rdy(pat, k);
      bus.PCSrcE     = pc;
      #2;
      if (bus.stall_cache) begin
        stall_n++;
        if (!bus.StallF || !bus.StallD || bus.FlushD || bus.FlushE) bad++;
      end else begin
        ended = 1'b1;
        if (pc) chk({tag, "_flush_after"}, {30'd0, bus.FlushD, bus.FlushE}, 32'd3);
      end
      if (bus.mem_req) req_n++;
      if (bus.refill_we) begin
        if (beat_q.size() == 0) chk({tag, "_extra_beat"}, 32'(bus.refill_beat), 32'hFFFF);
        else chk({tag, "_beat"}, 32'(bus.refill_beat), 32'(beat_q.pop_front()));
      end
    end
    chk({tag, "_ended"}, 32'(ended), 32'd1);
    chk({tag, "_stall_cycles"}, stall_n, last + 2);
    chk({tag, "_mem_req_cycles"}, req_n, 1);
    chk({tag, "_beats_left"}, beat_q.size(), 0);
    chk({tag, "_stall_ctrl"}, bad, 0);
    beat_q.delete();
  endtask

  initial begin
    drive_idle();
    repeat (2) @(negedge clk);
    #2;
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_refill_we", 32'(bus.refill_we), 0);
    chk("rst_refill_beat", 32'(bus.refill_beat), 0);
    chk("rst_stall_cache", 32'(bus.stall_cache), 0);
    bus.cache_miss = 1'b1;
    #1;
    chk("rst_stall_follows_miss", 32'(bus.stall_cache), 1);
    bus.cache_miss = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    hz("fwdA_mem", 0, 0, 5, 0, 0, 2'b00, 1, 5, 1, 5, 0, 8'b10_00_0000);
    hz("fwdA_wb",  0, 0, 5, 0, 0, 2'b00, 1, 0, 1, 5, 0, 8'b01_00_0000);
    hz("fwdB_wb",  0, 0, 5, 5, 0, 2'b00, 0, 5, 1, 5, 0, 8'b01_01_0000);
    hz("fwd_nowe", 0, 0, 5, 5, 0, 2'b00, 0, 5, 0, 5, 0, 8'b00_00_0000);
    hz("fwd_x0",   0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0, 8'b00_00_0000);
    hz("fwdB_mem", 0, 0, 3, 9, 0, 2'b00, 1, 9, 1, 3, 0, 8'b01_10_0000);
    hz("lu_rs2",   0, 7, 0, 0, 7, 2'b01, 0, 0, 0, 0, 0, 8'b00_00_1101);
    hz("lu_rd0",   0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 8'b00_00_0000);
    hz("lu_noload",7, 7, 0, 0, 7, 2'b00, 0, 0, 0, 0, 0, 8'b00_00_0000);
    hz("lu_rs1",   7, 0, 0, 0, 7, 2'b01, 0, 0, 0, 0, 0, 8'b00_00_1101);
    hz("br_over_lu",7,0, 0, 0, 7, 2'b01, 0, 0, 0, 0, 1, 8'b00_00_0011);
    hz("idle",     0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 8'b00_00_0000);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_lu", bus.load_use_cnt, 2);
    chk("perf_flush", bus.flush_cnt, 1);
    chk("perf_stall0", bus.stall_cycles, 0);
`endif

    run_refill("fill_rdy", 0, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall", bus.stall_cycles, RB + 3);
`endif
    run_refill("fill_toggle", 1, 1'b0);
    run_refill("fill_branch", 1, 1'b1);

    // Reset asserted mid-refill once beat 2 is being written.
    begin
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < 20 && !hit; k++) begin
        @(negedge clk);
        drive_idle();
        bus.cache_miss = (k == 0);
        bus.mem_ready  = 1'b1;
        #2;
        if (bus.refill_we && bus.refill_beat == 2'd2) hit = 1'b1;
      end
      chk("mid_rst_reached_beat2", 32'(hit), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_we", 32'(bus.refill_we), 0);
      chk("mid_rst_beat", 32'(bus.refill_beat), 0);
      chk("mid_rst_req", 32'(bus.mem_req), 0);
      chk("mid_rst_stall", 32'(bus.stall_cache), 0);
      bus.cache_miss = 1'b1;
      #1;
      chk("mid_rst_stall_miss", 32'(bus.stall_cache), 1);
      bus.cache_miss = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #2;
      chk("post_rst_stall", 32'(bus.stall_cache), 0);
    end
    run_refill("fill_after_rst", 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
